// File: rtl/mux_sel_arbiter.sv
// Two-source round-robin arbiter driving a 2:1 mux select; outputs registered, one-cycle latency.
// Sources hold the path until last, abandon or hold limit; the waiting source takes over with no bubble.
module mux_sel_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic             last_a,
  input  logic             last_b,
  output logic             sel,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             busy,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic             ptr_a, ptr_a_nxt;
  logic             sel_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr_a    <= 1'b1;
      sel      <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr_a    <= ptr_a_nxt;
      sel      <= sel_nxt;
      hold_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_a_nxt = ptr_a;
    sel_nxt   = sel;
    cnt_nxt   = hold_cnt;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (req_a && (ptr_a || !req_b)) begin
          state_nxt = GRANT_A;
          sel_nxt   = 1'b1;
        end else if (req_b) begin
          state_nxt = GRANT_B;
          sel_nxt   = 1'b0;
        end
      end
      GRANT_A: begin
        done = last_a || !req_a || (hold_cnt == CNT_MAX);
        if (done) begin
          ptr_a_nxt = 1'b0;
          cnt_nxt   = '0;
          // Hand over straight to b when it waits; otherwise a may continue only if still requesting.
          if (req_b) begin
            state_nxt = GRANT_B;
            sel_nxt   = 1'b0;
          end else if (!req_a) begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = hold_cnt + CNT_W'(1);
        end
      end
      GRANT_B: begin
        done = last_b || !req_b || (hold_cnt == CNT_MAX);
        if (done) begin
          ptr_a_nxt = 1'b1;
          cnt_nxt   = '0;
          if (req_a) begin
            state_nxt = GRANT_A;
            sel_nxt   = 1'b1;
          end else if (!req_b) begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign gnt_a = (state == GRANT_A);
  assign gnt_b = (state == GRANT_B);
  assign busy  = gnt_a | gnt_b;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: three instances (MAX_HOLD 16, 4, 1) on shared inputs, each against an ownership model.
module tb_mux_sel_arbiter;

  localparam int CNT_W = 5;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_a = 1'b0, req_b = 1'b0, last_a = 1'b0, last_b = 1'b0;

  logic             sel_o   [N];
  logic             gnt_a_o [N];
  logic             gnt_b_o [N];
  logic             busy_o  [N];
  logic [CNT_W-1:0] cnt_o   [N];

  int errors = 0;
  int checks = 0;

  // Model: owner 0=none 1=a 2=b, elapsed cycles in grant, which source is favoured, last select.
  int mh    [N] = '{16, 4, 1};
  int owner [N];
  int elap  [N];
  bit fav_a [N];
  bit msel  [N];

  always #5 clk = ~clk;

  mux_sel_arbiter #(.MAX_HOLD(16), .CNT_W(CNT_W)) u_d16 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b), .last_a(last_a), .last_b(last_b),
    .sel(sel_o[0]), .gnt_a(gnt_a_o[0]), .gnt_b(gnt_b_o[0]), .busy(busy_o[0]), .hold_cnt(cnt_o[0]));
  mux_sel_arbiter #(.MAX_HOLD(4), .CNT_W(CNT_W)) u_d4 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b), .last_a(last_a), .last_b(last_b),
    .sel(sel_o[1]), .gnt_a(gnt_a_o[1]), .gnt_b(gnt_b_o[1]), .busy(busy_o[1]), .hold_cnt(cnt_o[1]));
  mux_sel_arbiter #(.MAX_HOLD(1), .CNT_W(CNT_W)) u_d1 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b), .last_a(last_a), .last_b(last_b),
    .sel(sel_o[2]), .gnt_a(gnt_a_o[2]), .gnt_b(gnt_b_o[2]), .busy(busy_o[2]), .hold_cnt(cnt_o[2]));

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[dut%0d] observed=%0h expected=%0h at %0t", tag, k, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      owner[k] = 0; elap[k] = 0; fav_a[k] = 1'b1; msel[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input bit ra, input bit rb, input bit la, input bit lb);
    bit mine, other, lst;
    if (owner[k] == 0) begin
      elap[k] = 0;
      if (ra && (fav_a[k] || !rb)) begin owner[k] = 1; msel[k] = 1'b1; end
      else if (rb) begin owner[k] = 2; msel[k] = 1'b0; end
    end else begin
      mine  = (owner[k] == 1) ? ra : rb;
      other = (owner[k] == 1) ? rb : ra;
      lst   = (owner[k] == 1) ? la : lb;
      if (lst || !mine || elap[k] >= mh[k] - 1) begin
        fav_a[k] = (owner[k] == 2);
        elap[k] = 0;
        if (other) begin owner[k] = 3 - owner[k]; msel[k] = (owner[k] == 1); end
        else if (!mine) owner[k] = 0;
      end else begin
        elap[k] = elap[k] + 1;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < N; k++) begin
      chk("gnt_a", k, 32'(gnt_a_o[k]), 32'(owner[k] == 1));
      chk("gnt_b", k, 32'(gnt_b_o[k]), 32'(owner[k] == 2));
      chk("busy", k, 32'(busy_o[k]), 32'(owner[k] != 0));
      chk("sel", k, 32'(sel_o[k]), 32'(msel[k]));
      chk("hold_cnt", k, 32'(cnt_o[k]), 32'(elap[k]));
      chk("mutex", k, 32'(gnt_a_o[k] & gnt_b_o[k]), 32'd0);
    end
  endtask

  // Called at a falling edge: drive, clock, advance model, then compare at the next falling edge.
  task automatic cyc(input bit ra, input bit rb, input bit la, input bit lb);
    req_a = ra; req_b = rb; last_a = la; last_b = lb;
    @(posedge clk);
    for (int k = 0; k < N; k++) model_step(k, ra, rb, la, lb);
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous reset asserted mid-cycle with both sources requesting.
  task automatic do_reset();
    req_a = 1'b1; req_b = 1'b1; last_a = 1'b0; last_b = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1 compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Single request with last on the 4th grant cycle, then immediate re-grant.
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
    chk("single_cnt3", 0, 32'(cnt_o[0]), 32'd3);
    chk("single_sel", 0, 32'(sel_o[0]), 32'd1);
    cyc(1, 0, 1, 0);
    chk("regrant_gnt", 0, 32'(gnt_a_o[0]), 32'd1);
    chk("regrant_cnt", 0, 32'(cnt_o[0]), 32'd0);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 0);

    // Contention: last on the 2nd grant cycle of each grant (driven from dut0's visible state).
    do_reset();
    for (int i = 0; i < 12; i++)
      cyc(1, 1, gnt_a_o[0] && cnt_o[0] == 1, gnt_b_o[0] && cnt_o[0] == 1);
    cyc(0, 0, 0, 0);

    // Forced release on the MAX_HOLD=4 instance.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
    chk("force_a_cnt", 1, 32'(cnt_o[1]), 32'd3);
    chk("force_a_gnt", 1, 32'(gnt_a_o[1]), 32'd1);
    cyc(1, 1, 0, 0);
    chk("force_b_gnt", 1, 32'(gnt_b_o[1]), 32'd1);
    chk("force_b_cnt", 1, 32'(cnt_o[1]), 32'd0);
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0);

    // Abandon by b with a idle, then a request.
    do_reset();
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("abandon_busy", 0, 32'(busy_o[0]), 32'd0);
    chk("abandon_sel", 0, 32'(sel_o[0]), 32'd0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("after_abandon_sel", 0, 32'(sel_o[0]), 32'd1);

    // Reset mid-grant with b at hold_cnt 5.
    do_reset();
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0);
    chk("midgrant_cnt5", 0, 32'(cnt_o[0]), 32'd5);
    do_reset();
    cyc(1, 1, 0, 0);
    chk("post_reset_a", 0, 32'(gnt_a_o[0]), 32'd1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) do_reset();
      cyc($urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0,
          $urandom_range(3, 0) == 0, $urandom_range(3, 0) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
